// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - address map constants and defaults for the PWM register bank
package pwm_pkg;

    localparam int DEFAULT_REG_WIDTH    = 16;
    localparam int DEFAULT_NUM_CHANNELS = 4;

    localparam logic [4:0] ADDR_PRESCALE = 5'h00;

    function automatic logic [4:0] period_addr(input int unsigned ch);
        return 5'(32'd1 + 32'd2 * ch);
    endfunction

    function automatic logic [4:0] duty_addr(input int unsigned ch);
        return 5'(32'd2 + 32'd2 * ch);
    endfunction

endpackage

// File: rtl/pwm_regs.sv
// rtl/pwm_regs.sv - PWM configuration register bank with combinational read mux
module pwm_regs
    import pwm_pkg::*;
#(
    parameter int REG_WIDTH    = DEFAULT_REG_WIDTH,
    parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_en,
    input  logic [4:0]           write_addr,
    input  logic [31:0]          write_data,
    input  logic                 read_en,
    input  logic [4:0]           read_addr,
    output logic [31:0]          read_data,
    output logic [REG_WIDTH-1:0] prescale,
    output logic [REG_WIDTH-1:0] period [NUM_CHANNELS],
    output logic [REG_WIDTH-1:0] duty   [NUM_CHANNELS]
);

    // The whole map must fit in the 5-bit address space and registers in the 32-bit bus.
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 15 || REG_WIDTH < 1 || REG_WIDTH > 32) begin : g_param_check
        $error("pwm_regs: NUM_CHANNELS must be 1..15 and REG_WIDTH 1..32");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                period[i] <= '0;
                duty[i]   <= '0;
            end
        end else if (write_en) begin
            if (write_addr == ADDR_PRESCALE)
                prescale <= write_data[REG_WIDTH-1:0];
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (write_addr == period_addr(i))
                    period[i] <= write_data[REG_WIDTH-1:0];
                if (write_addr == duty_addr(i))
                    duty[i] <= write_data[REG_WIDTH-1:0];
            end
        end
    end

    // Unmapped addresses simply match nothing and fall through to zero.
    always_comb begin
        read_data = '0;
        if (read_en) begin
            if (read_addr == ADDR_PRESCALE)
                read_data[REG_WIDTH-1:0] = prescale;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (read_addr == period_addr(i))
                    read_data[REG_WIDTH-1:0] = period[i];
                if (read_addr == duty_addr(i))
                    read_data[REG_WIDTH-1:0] = duty[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_regs.sv
// tb/tb_pwm_regs.sv - directed self-checking bench for pwm_regs
module tb_pwm_regs;

    localparam int RW = 16;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en;
    logic [4:0]    write_addr;
    logic [31:0]   write_data;
    logic          read_en;
    logic [4:0]    read_addr;
    logic [31:0]   read_data;
    logic [RW-1:0] prescale;
    logic [RW-1:0] period [NC];
    logic [RW-1:0] duty   [NC];

    int errors = 0;
    int checks = 0;

    pwm_regs #(.REG_WIDTH(RW), .NUM_CHANNELS(NC)) dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
        .prescale(prescale), .period(period), .duty(duty)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_en = 1'b1; write_addr = a; write_data = d;
        @(posedge clk); #1;
        write_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        read_en = 1'b1;
        for (int a = 0; a <= 8; a++) begin
            read_addr = 5'(a); #1;
            checks++;
            if (read_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", a, read_data);
            end
        end
        checks++;
        if (prescale !== '0) begin errors++; $display("FAIL reset_prescale got=%h exp=0", prescale); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (period[i] !== '0 || duty[i] !== '0) begin
                errors++;
                $display("FAIL reset_ch%0d period=%h duty=%h exp=0", i, period[i], duty[i]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [4:0]  addrs [5] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04};
        logic [31:0] vals  [5] = '{32'd123, 32'd1000, 32'd500, 32'd2000, 32'd1000};
        for (int k = 0; k < 5; k++) wr(addrs[k], vals[k]);
        read_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            read_addr = addrs[k]; #1;
            checks++;
            if (read_data !== vals[k]) begin
                errors++;
                $display("FAIL wr_read addr=%0d got=%0d exp=%0d", addrs[k], read_data, vals[k]);
            end
        end
        checks++;
        if (prescale !== 16'd123 || period[0] !== 16'd1000 || duty[0] !== 16'd500 ||
            period[1] !== 16'd2000 || duty[1] !== 16'd1000) begin
            errors++;
            $display("FAIL wr_outputs got=%0d/%0d/%0d/%0d/%0d exp=123/1000/500/2000/1000",
                     prescale, period[0], duty[0], period[1], duty[1]);
        end
        checks++;
        if (period[2] !== '0 || duty[3] !== '0) begin
            errors++;
            $display("FAIL wr_untouched period2=%0d duty3=%0d exp=0", period[2], duty[3]);
        end
    endtask

    task automatic test_truncate();
        wr(5'h00, 32'hABCD_1234);
        read_en = 1'b1; read_addr = 5'h00; #1;
        checks++;
        if (prescale !== 16'h1234) begin errors++; $display("FAIL trunc_prescale got=%h exp=1234", prescale); end
        checks++;
        if (read_data !== 32'h0000_1234) begin errors++; $display("FAIL trunc_read got=%h exp=00001234", read_data); end
    endtask

    task automatic test_unmapped();
        for (int a = 0; a <= 8; a++) wr(5'(a), 32'd7);
        wr(5'h1F, 32'd55);
        wr(5'h09, 32'd66);
        checks++;
        if (prescale !== 16'd7) begin errors++; $display("FAIL unmapped_prescale got=%0d exp=7", prescale); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (period[i] !== 16'd7 || duty[i] !== 16'd7) begin
                errors++;
                $display("FAIL unmapped_ch%0d period=%0d duty=%0d exp=7", i, period[i], duty[i]);
            end
        end
        read_en = 1'b1;
        read_addr = 5'h1F; #1;
        checks++;
        if (read_data !== 32'h0) begin errors++; $display("FAIL unmapped_read1f got=%h exp=0", read_data); end
        read_addr = 5'h09; #1;
        checks++;
        if (read_data !== 32'h0) begin errors++; $display("FAIL unmapped_read09 got=%h exp=0", read_data); end
    endtask

    task automatic test_same_edge();
        read_en = 1'b1; read_addr = 5'h08;
        write_en = 1'b1; write_addr = 5'h08; write_data = 32'd77;
        #1;
        checks++;
        if (read_data !== 32'd7) begin errors++; $display("FAIL same_edge_before got=%0d exp=7", read_data); end
        @(posedge clk); #1;
        write_en = 1'b0;
        checks++;
        if (read_data !== 32'd77) begin errors++; $display("FAIL same_edge_after got=%0d exp=77", read_data); end
        checks++;
        if (duty[3] !== 16'd77) begin errors++; $display("FAIL same_edge_duty3 got=%0d exp=77", duty[3]); end
    endtask

    task automatic test_back_to_back();
        write_en = 1'b1;
        for (int i = 0; i < NC; i++) begin
            write_addr = 5'(1 + 2 * i); write_data = 32'(100 + i);
            @(posedge clk); #1;
            write_addr = 5'(2 + 2 * i); write_data = 32'(200 + i);
            @(posedge clk); #1;
        end
        write_en = 1'b0;
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (period[i] !== 16'(100 + i) || duty[i] !== 16'(200 + i)) begin
                errors++;
                $display("FAIL b2b_ch%0d period=%0d duty=%0d exp=%0d/%0d", i, period[i], duty[i], 100 + i, 200 + i);
            end
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1;
        write_en = 1'b1; write_addr = 5'h01; write_data = 32'd9;
        @(posedge clk); #1;
        write_en = 1'b0;
        checks++;
        if (period[0] !== '0) begin errors++; $display("FAIL rst_prio_period0 got=%0d exp=0", period[0]); end
        read_en = 1'b1; read_addr = 5'h08; #1;
        checks++;
        if (read_data !== 32'h0) begin errors++; $display("FAIL rst_read_during got=%h exp=0", read_data); end
        rst = 1'b0;
        wr(5'h03, 32'd44);
        read_en = 1'b0;
        for (int a = 0; a <= 8; a++) begin
            read_addr = 5'(a); #1;
            checks++;
            if (read_data !== 32'h0) begin
                errors++;
                $display("FAIL read_en_low addr=%0d got=%h exp=0", a, read_data);
            end
        end
        checks++;
        if (period[1] !== 16'd44 || prescale !== '0 || duty[3] !== '0) begin
            errors++;
            $display("FAIL rst_discard period1=%0d prescale=%0d duty3=%0d exp=44/0/0", period[1], prescale, duty[3]);
        end
    endtask

    initial begin
        rst = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
        read_en = 1'b0; read_addr = '0;
        test_reset();
        test_write_read();
        test_truncate();
        test_unmapped();
        test_same_edge();
        test_back_to_back();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
